// File: rtl/ws2811_frame_sequencer_if.sv
// Pixel-store read port, frame control and LED line of the WS2811 frame sequencer.
// The slave modport is the sequencer side; master is the controller/frame-buffer side.
interface ws2811_frame_sequencer_if #(
    parameter int unsigned PIXELS = 8
);
    localparam int unsigned AddrW = (PIXELS > 1) ? $clog2(PIXELS) : 1;

    logic             startIN;
    logic             busyOUT;
    logic             doneOUT;
    logic             underrunOUT;
    logic             pixelReqOUT;
    logic [AddrW-1:0] pixelAddrOUT;
    logic             pixelAckIN;
    logic [23:0]      pixelDataIN;
    logic             dataOUT;

    modport master (
        output startIN, pixelAckIN, pixelDataIN,
        input  busyOUT, doneOUT, underrunOUT, pixelReqOUT, pixelAddrOUT, dataOUT
    );

    modport slave (
        input  startIN, pixelAckIN, pixelDataIN,
        output busyOUT, doneOUT, underrunOUT, pixelReqOUT, pixelAddrOUT, dataOUT
    );
endinterface

// File: rtl/ws2811_frame_sequencer.sv
// Streams one WS2811 frame: fetches PIXELS GRB words, serializes them MSB-first with a
// one-word prefetch buffer for gapless pixel boundaries, then holds the latch period.
module ws2811_frame_sequencer #(
    parameter int unsigned PIXELS      = 8,
    parameter int unsigned BIT_TICKS   = 60,
    parameter int unsigned T0H_TICKS   = 12,
    parameter int unsigned T1H_TICKS   = 29,
    parameter int unsigned RESET_TICKS = 2500
) (
    input logic                      clkIN,
    input logic                      resetIN,
    ws2811_frame_sequencer_if.slave  bus
);
    localparam int unsigned AddrW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int unsigned NxtW  = $clog2(PIXELS + 1);
    localparam int unsigned TickW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int unsigned LatW  = (RESET_TICKS > 1) ? $clog2(RESET_TICKS) : 1;

    localparam logic [TickW-1:0] TickLast = TickW'(BIT_TICKS - 1);
    localparam logic [TickW-1:0] T0High   = TickW'(T0H_TICKS);
    localparam logic [TickW-1:0] T1High   = TickW'(T1H_TICKS);
    localparam logic [LatW-1:0]  LatLast  = LatW'(RESET_TICKS - 1);
    localparam logic [AddrW-1:0] PixLast  = AddrW'(PIXELS - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StSend, StStall, StLatch} state_e;

    state_e           state_q, state_d;
    logic [23:0]      shift_q, shift_d;
    logic [23:0]      buf_q, buf_d;
    logic             buf_vld_q, buf_vld_d;
    logic [4:0]       bit_idx_q, bit_idx_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [LatW-1:0]  lat_q, lat_d;
    logic [AddrW-1:0] pix_q, pix_d;
    logic [NxtW-1:0]  nxt_q, nxt_d;
    logic             req_q, req_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;

    logic ack, tick_end, last_pix, need_fetch;

    assign ack        = req_q & bus.pixelAckIN;
    assign tick_end   = (tick_q == TickLast);
    assign last_pix   = (pix_q == PixLast);
    assign need_fetch = (nxt_q < NxtW'(PIXELS));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        bit_idx_d  = bit_idx_q;
        tick_d     = tick_q;
        lat_d      = lat_q;
        pix_d      = pix_q;
        nxt_d      = nxt_q;
        req_d      = req_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;

        unique case (state_q)
            StIdle: begin
                if (bus.startIN) begin
                    state_d    = StFetch;
                    req_d      = 1'b1;
                    addr_d     = '0;
                    nxt_d      = NxtW'(1);
                    pix_d      = '0;
                    buf_vld_d  = 1'b0;
                    busy_d     = 1'b1;
                    underrun_d = 1'b0;
                end
            end
            StFetch: begin
                if (ack) begin
                    shift_d   = bus.pixelDataIN;
                    bit_idx_d = 5'd23;
                    tick_d    = '0;
                    req_d     = 1'b0;
                    state_d   = StSend;
                end
            end
            StSend: begin
                tick_d = tick_q + TickW'(1);
                if (ack) begin
                    buf_d     = bus.pixelDataIN;
                    buf_vld_d = 1'b1;
                    req_d     = 1'b0;
                end
                if (tick_end) begin
                    tick_d = '0;
                    if (bit_idx_q != 5'd0) begin
                        shift_d   = {shift_q[22:0], 1'b0};
                        bit_idx_d = bit_idx_q - 5'd1;
                    end else if (last_pix) begin
                        state_d = StLatch;
                        lat_d   = '0;
                    end else if (buf_vld_q) begin
                        shift_d   = buf_q;
                        buf_vld_d = 1'b0;
                        bit_idx_d = 5'd23;
                        pix_d     = pix_q + AddrW'(1);
                    end else if (ack) begin
                        // Ack arriving on the boundary goes straight to the shifter.
                        shift_d   = bus.pixelDataIN;
                        buf_vld_d = 1'b0;
                        bit_idx_d = 5'd23;
                        pix_d     = pix_q + AddrW'(1);
                    end else begin
                        state_d    = StStall;
                        underrun_d = 1'b1;
                    end
                end
            end
            StStall: begin
                if (ack) begin
                    shift_d   = bus.pixelDataIN;
                    bit_idx_d = 5'd23;
                    tick_d    = '0;
                    req_d     = 1'b0;
                    pix_d     = pix_q + AddrW'(1);
                    state_d   = StSend;
                end
            end
            StLatch: begin
                lat_d = lat_q + LatW'(1);
                if (lat_q == LatLast) begin
                    lat_d   = '0;
                    state_d = StIdle;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Prefetch: refill the empty buffer with the next pixel while the current one shifts out.
        if ((state_q == StSend || state_q == StStall) && !req_q && !buf_vld_q && need_fetch) begin
            req_d  = 1'b1;
            addr_d = AddrW'(nxt_q);
            nxt_d  = nxt_q + NxtW'(1);
        end
    end

    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_vld_q  <= 1'b0;
            bit_idx_q  <= '0;
            tick_q     <= '0;
            lat_q      <= '0;
            pix_q      <= '0;
            nxt_q      <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            bit_idx_q  <= bit_idx_d;
            tick_q     <= tick_d;
            lat_q      <= lat_d;
            pix_q      <= pix_d;
            nxt_q      <= nxt_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign bus.dataOUT      = (state_q == StSend) && (tick_q < (shift_q[23] ? T1High : T0High));
    assign bus.busyOUT      = busy_q;
    assign bus.doneOUT      = done_q;
    assign bus.underrunOUT  = underrun_q;
    assign bus.pixelReqOUT  = req_q;
    assign bus.pixelAddrOUT = addr_q;
endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Randomized bench: a read-port responder pushes the expected bit symbols of each delivered
// pixel into a scoreboard; a line monitor decodes dataOUT and checks symbols and frame end.
module tb_ws2811_frame_sequencer;
    localparam int unsigned NPIX = 3;
    localparam int BT  = 60;
    localparam int T0H = 12;
    localparam int T1H = 29;
    localparam int RT  = 2500;

    typedef struct packed {
        logic val;
        logic stall;
    } sym_t;

    logic clkIN = 1'b0;
    logic resetIN;
    always #5 clkIN = ~clkIN;

    ws2811_frame_sequencer_if #(.PIXELS(NPIX)) bus ();

    ws2811_frame_sequencer #(
        .PIXELS     (NPIX),
        .BIT_TICKS  (BT),
        .T0H_TICKS  (T0H),
        .T1H_TICKS  (T1H),
        .RESET_TICKS(RT)
    ) dut (
        .clkIN  (clkIN),
        .resetIN(resetIN),
        .bus    (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [23:0] pix [NPIX];
    int          late_idx = 0;
    int          fast_max = 0;
    bit          stray_en = 1'b0;
    bit          exp_underrun = 1'b0;
    int          next_addr = 0;
    int          done_cnt = 0;
    sym_t        exp_q[$];

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Read-port responder: random latency, optional late ack, stray acks while idle.
    initial begin
        bit          pend = 1'b0;
        int          wait_cnt = 0;
        int          req_addr = 0;
        int          a;
        bit          late;
        logic [23:0] w;
        bus.pixelAckIN  = 1'b0;
        bus.pixelDataIN = '0;
        forever begin
            @(negedge clkIN);
            bus.pixelAckIN  = 1'b0;
            bus.pixelDataIN = 24'($urandom);
            if (resetIN) begin
                pend = 1'b0;
                continue;
            end
            if (bus.pixelReqOUT) begin
                if (!pend) begin
                    pend     = 1'b1;
                    req_addr = int'(bus.pixelAddrOUT);
                    late     = (late_idx != 0) && (req_addr == late_idx);
                    wait_cnt = late ? int'($urandom_range(1700, 1500))
                                    : int'($urandom_range(fast_max, 0));
                end
                if (wait_cnt == 0) begin
                    a = int'(bus.pixelAddrOUT);
                    chk("ack_addr_order", a == next_addr, a, next_addr);
                    chk("ack_addr_stable", a == req_addr, a, req_addr);
                    if (a >= int'(NPIX)) a = 0;
                    late = (late_idx != 0) && (a == late_idx);
                    w = pix[a];
                    bus.pixelAckIN  = 1'b1;
                    bus.pixelDataIN = w;
                    for (int b = 23; b >= 0; b--) begin
                        exp_q.push_back('{val: w[b], stall: (b == 23) && late});
                    end
                    if (late) exp_underrun = 1'b1;
                    next_addr++;
                    pend = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end else if (stray_en && $urandom_range(7, 0) == 0) begin
                bus.pixelAckIN = 1'b1;
            end
        end
    end

    // Line monitor: decode symbols from dataOUT and check against the scoreboard.
    initial begin
        logic prev;
        int   hi, lo, rise_cyc, cyc, req_hi;
        bit   have;
        sym_t cur;
        prev = 1'b0; hi = 0; lo = 0; rise_cyc = 0; cyc = 0; have = 1'b0; cur = '0;
        forever begin
            @(negedge clkIN);
            cyc++;
            if (resetIN) begin
                exp_q.delete();
                prev = 1'b0; hi = 0; lo = 0; have = 1'b0;
                continue;
            end
            if (bus.dataOUT && !prev) begin
                chk("symbol_expected", exp_q.size() != 0, 1, 0);
                cur = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if (have) begin
                    if (cur.stall) begin
                        chk("stall_gap", hi + lo > BT, hi + lo, BT + 1);
                        chk("underrun_set", bus.underrunOUT == 1'b1, bus.underrunOUT, 1);
                    end else begin
                        chk("bit_period", hi + lo == BT, hi + lo, BT);
                    end
                end
                have = 1'b1; hi = 1; lo = 0; rise_cyc = cyc;
            end else if (bus.dataOUT) begin
                hi++;
            end else if (prev) begin
                req_hi = cur.val ? T1H : T0H;
                chk("high_time", hi == req_hi, hi, req_hi);
                lo = 1;
            end else begin
                lo++;
            end
            prev = bus.dataOUT;
            if (bus.doneOUT) begin
                done_cnt++;
                chk("latch_len", have && (cyc - rise_cyc == BT + RT), cyc - rise_cyc, BT + RT);
                chk("done_busy_low", bus.busyOUT == 1'b0, bus.busyOUT, 0);
                chk("underrun_final", bus.underrunOUT == exp_underrun, bus.underrunOUT,
                    exp_underrun);
                chk("all_bits_sent", exp_q.size() == 0, exp_q.size(), 0);
                have = 1'b0;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clkIN);
        bus.startIN = 1'b1;
        @(negedge clkIN);
        bus.startIN = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clkIN);
        exp_underrun = 1'b0;
        next_addr    = 0;
        bus.startIN  = 1'b1;
        @(negedge clkIN);
        bus.startIN = 1'b0;
        chk("start_busy", bus.busyOUT == 1'b1, bus.busyOUT, 1);
        chk("start_underrun_clear", bus.underrunOUT == 1'b0, bus.underrunOUT, 0);
        chk("start_req", bus.pixelReqOUT == 1'b1, bus.pixelReqOUT, 1);
        chk("start_addr", bus.pixelAddrOUT == '0, bus.pixelAddrOUT, 0);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clkIN);
            if (bus.doneOUT) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_timeout", ok, ok, 1);
        @(negedge clkIN);
        chk("done_one_cycle", !bus.doneOUT && !bus.busyOUT, {bus.doneOUT, bus.busyOUT}, 0);
    endtask

    task automatic run_frame(input int f);
        int dc;
        int quiet;
        for (int p = 0; p < int'(NPIX); p++) pix[p] = 24'($urandom);
        if (f == 0) begin
            pix[0] = 24'hFF0000;
            pix[1] = 24'h000001;
        end
        late_idx = (f == 2) ? 1 : (f == 3) ? 2 : (f == 5) ? 1 : 0;
        stray_en = (f != 0);
        fast_max = (f == 0) ? 0 : 30;
        dc = done_cnt;
        start_frame();
        if (f == 3) begin
            repeat (300) @(negedge clkIN);
            pulse_start();
            quiet = 0;
            for (int i = 0; i < 8000 && quiet < 400; i++) begin
                @(negedge clkIN);
                quiet = bus.dataOUT ? 0 : quiet + 1;
            end
            pulse_start();
        end
        wait_done();
        repeat (20) @(negedge clkIN);
        chk("one_done_per_frame", done_cnt == dc + 1, done_cnt - dc, 1);
        chk("idle_after_frame", !bus.busyOUT && !bus.pixelReqOUT,
            {bus.busyOUT, bus.pixelReqOUT}, 0);
    endtask

    initial begin
        resetIN     = 1'b1;
        bus.startIN = 1'b0;
        repeat (4) @(negedge clkIN);
        resetIN  = 1'b0;
        stray_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clkIN);
            chk("idle_outputs",
                {bus.dataOUT, bus.pixelReqOUT, bus.busyOUT, bus.doneOUT, bus.underrunOUT} == '0,
                {bus.dataOUT, bus.pixelReqOUT, bus.busyOUT, bus.doneOUT, bus.underrunOUT}, 0);
        end

        for (int f = 0; f < 6; f++) run_frame(f);

        // Reset in the middle of a bit symbol.
        late_idx = 0;
        fast_max = 10;
        for (int p = 0; p < int'(NPIX); p++) pix[p] = 24'($urandom);
        start_frame();
        repeat (700) @(negedge clkIN);
        resetIN = 1'b1;
        @(posedge clkIN);
        #1;
        chk("reset_data", bus.dataOUT == 1'b0, bus.dataOUT, 0);
        chk("reset_req", bus.pixelReqOUT == 1'b0, bus.pixelReqOUT, 0);
        chk("reset_busy", bus.busyOUT == 1'b0, bus.busyOUT, 0);
        chk("reset_addr", bus.pixelAddrOUT == '0, bus.pixelAddrOUT, 0);
        @(negedge clkIN);
        @(negedge clkIN);
        resetIN = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clkIN);
            chk("post_reset_idle", {bus.dataOUT, bus.busyOUT, bus.pixelReqOUT} == '0,
                {bus.dataOUT, bus.busyOUT, bus.pixelReqOUT}, 0);
        end

        run_frame(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
